// File: rtl/mem_access_pkg.sv
// Shared types for the data-memory access unit: op encoding, FSM states,
// default window size and small decode helpers.
package mem_access_pkg;

  localparam int ADDR_BITS_DEFAULT = 12;

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LH  = 3'd1,
    LHU = 3'd2,
    LB  = 3'd3,
    LBU = 3'd4,
    SW  = 3'd5,
    SH  = 3'd6,
    SB  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2,
    RESP   = 2'd3
  } state_e;

  function automatic logic is_load(op_e op);
    logic r;
    case (op)
      LW, LH, LHU, LB, LBU: r = 1'b1;
      default:              r = 1'b0;
    endcase
    return r;
  endfunction

  // Words need 4-byte alignment, halfwords 2-byte; bytes are always aligned.
  function automatic logic is_misaligned(op_e op, logic [1:0] lo);
    logic r;
    case (op)
      LW, SW:      r = (lo != 2'b00);
      LH, LHU, SH: r = lo[0];
      default:     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Request/response and memory-port bundle. The unit takes the slave side;
// the pipeline plus memory take the master side.
interface mem_access_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_pc, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_pc, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit_byte_lane.sv
// byte_lane_unit: little-endian lane extraction with sign/zero extension,
// and lane replacement for sub-word stores. Purely combinational.
module byte_lane_unit
  import mem_access_pkg::*;
(
  input  op_e         op,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] sdata,
  output logic [31:0] load_val,
  output logic [31:0] store_word
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed lane, then extend it or splice store data into it.
  always_comb begin
    byte_s     = word[{lane, 3'b000} +: 8];
    half_s     = lane[1] ? word[31:16] : word[15:0];
    load_val   = 32'd0;
    store_word = word;
    case (op)
      LW:  load_val = word;
      LH:  load_val = {{16{half_s[15]}}, half_s};
      LHU: load_val = {16'd0, half_s};
      LB:  load_val = {{24{byte_s[7]}}, byte_s};
      LBU: load_val = {24'd0, byte_s};
      SW:  store_word = sdata;
      SH: begin
        if (lane[1]) begin
          store_word = {sdata[15:0], word[15:0]};
        end else begin
          store_word = {word[31:16], sdata[15:0]};
        end
      end
      SB:  store_word[{lane, 3'b000} +: 8] = sdata[7:0];
      default: begin
        load_val   = 32'd0;
        store_word = word;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side load/store initiator; sub-word stores are read-modify-write.
// Define MEM_ACCESS_DISPLAY_EN to log every memory write in simulation.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  mem_access_if.slave   bus
);

  state_e      state_r, state_s;
  op_e         op_r, op_s, req_op_s;
  logic [1:0]  lane_r, lane_s;
  logic [31:0] wdata_r, wdata_s;
  logic        req_ready_r, req_ready_s;
  logic        rsp_valid_r, rsp_valid_s;
  logic [31:0] rsp_rdata_r, rsp_rdata_s;
  logic        rsp_err_r, rsp_err_s;
  logic [31:0] mem_addr_r, mem_addr_s;
  logic        mem_we_r, mem_we_s;
  logic [31:0] mem_wdata_r, mem_wdata_s;
  logic        out_of_window_s;
  logic [31:0] load_val_s, store_word_s;

  assign req_op_s        = op_e'(bus.req_op);
  assign out_of_window_s = (bus.req_addr >> ADDR_BITS) != 32'd0;

  byte_lane_unit u_lane (
    .op         (op_r),
    .lane       (lane_r),
    .word       (bus.mem_rdata),
    .sdata      (wdata_r),
    .load_val   (load_val_s),
    .store_word (store_word_s)
  );

  // Next state and next registered outputs; everything idles at zero.
  always_comb begin
    state_s     = state_r;
    op_s        = op_r;
    lane_s      = lane_r;
    wdata_s     = wdata_r;
    req_ready_s = 1'b0;
    rsp_valid_s = 1'b0;
    rsp_rdata_s = 32'd0;
    rsp_err_s   = 1'b0;
    mem_addr_s  = 32'd0;
    mem_we_s    = 1'b0;
    mem_wdata_s = 32'd0;
    case (state_r)
      IDLE: begin
        if (bus.req_valid) begin
          op_s    = req_op_s;
          lane_s  = bus.req_addr[1:0];
          wdata_s = bus.req_wdata;
          if (out_of_window_s || is_misaligned(req_op_s, bus.req_addr[1:0])) begin
            state_s     = RESP;
            rsp_valid_s = 1'b1;
            rsp_err_s   = 1'b1;
          end else begin
            state_s    = ACCESS;
            mem_addr_s = {bus.req_addr[31:2], 2'b00};
            if (req_op_s == SW) begin
              mem_we_s    = 1'b1;
              mem_wdata_s = bus.req_wdata;
            end else begin
              mem_we_s    = 1'b0;
            end
          end
        end else begin
          req_ready_s = 1'b1;
        end
      end
      ACCESS: begin
        if (is_load(op_r)) begin
          state_s     = RESP;
          rsp_valid_s = 1'b1;
          rsp_rdata_s = load_val_s;
        end else if (op_r == SW) begin
          state_s     = RESP;
          rsp_valid_s = 1'b1;
        end else begin
          // The word read this cycle is merged now and written in MERGE.
          state_s     = MERGE;
          mem_addr_s  = mem_addr_r;
          mem_we_s    = 1'b1;
          mem_wdata_s = store_word_s;
        end
      end
      MERGE: begin
        state_s     = RESP;
        rsp_valid_s = 1'b1;
      end
      RESP: begin
        state_s     = IDLE;
        req_ready_s = 1'b1;
      end
      default: begin
        state_s     = IDLE;
        req_ready_s = 1'b1;
      end
    endcase
  end

  // State, request latch and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      op_r        <= LW;
      lane_r      <= 2'd0;
      wdata_r     <= 32'd0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'd0;
      rsp_err_r   <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_we_r    <= 1'b0;
      mem_wdata_r <= 32'd0;
    end else begin
      state_r     <= state_s;
      op_r        <= op_s;
      lane_r      <= lane_s;
      wdata_r     <= wdata_s;
      req_ready_r <= req_ready_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_rdata_r <= rsp_rdata_s;
      rsp_err_r   <= rsp_err_s;
      mem_addr_r  <= mem_addr_s;
      mem_we_r    <= mem_we_s;
      mem_wdata_r <= mem_wdata_s;
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.mem_addr  = mem_addr_r;
  // Reset low must block the write even mid-operation.
  assign bus.mem_we    = mem_we_r & reset;
  assign bus.mem_wdata = mem_wdata_r;

`ifdef MEM_ACCESS_DISPLAY_EN
  logic [31:0] pc_r;

  // Issuing PC, kept only for the write log.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_r <= 32'd0;
    end else if (state_r == IDLE && bus.req_valid) begin
      pc_r <= bus.req_pc;
    end else begin
      pc_r <= pc_r;
    end
  end

  // One log line per memory write cycle.
  always_ff @(posedge clk) begin
    if (mem_we_r && reset) begin
      $display("@%h: *%h <= %h", pc_r, mem_addr_r, mem_wdata_r);
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: per-cycle timeline model plus directed vectors.
module tb_mem_access_unit;

  localparam logic [2:0] OLW = 3'd0, OLH = 3'd1, OLHU = 3'd2, OLB = 3'd3,
                         OLBU = 3'd4, OSW = 3'd5, OSH = 3'd6, OSB = 3'd7;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_access_if bus();

  mem_access_unit #(.ADDR_BITS(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory: combinational read, write on the clock edge.
  logic [31:0] tbmem [0:1023];
  assign bus.mem_rdata = tbmem[bus.mem_addr[11:2]];
  always @(posedge clk) begin
    if (bus.mem_we) tbmem[bus.mem_addr[11:2]] <= bus.mem_wdata;
  end

  int n_total = 0;
  int n_bad = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for one cycle.
  typedef struct packed {
    logic        ready;
    logic        rv;
    logic        err;
    logic        we;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [0:1023];

  function automatic exp_t mk(logic ready, logic rv, logic err, logic we,
                              logic [31:0] rdata, logic [31:0] addr, logic [31:0] wdata);
    exp_t e;
    e.ready = ready; e.rv = rv; e.err = err; e.we = we;
    e.rdata = rdata; e.addr = addr; e.wdata = wdata;
    return e;
  endfunction

  // Queue the outputs an accepted request must produce, cycle by cycle.
  function automatic void model_accept(logic [2:0] op, logic [31:0] a, logic [31:0] wd);
    logic [31:0] w, base, val, nw;
    logic [7:0]  b;
    logic [15:0] h;
    int          sb, shh;
    logic        bad;
    base = a & 32'hFFFF_FFFC;
    w    = model_mem[a[11:2]];
    sb   = 8 * int'(a[1:0]);
    shh  = 16 * int'(a[1]);
    b    = 8'((w >> sb) & 32'hFF);
    h    = 16'((w >> shh) & 32'hFFFF);
    bad  = (a >= 32'h0000_1000) ||
           ((op == OLW || op == OSW) && (a % 4 != 0)) ||
           ((op == OLH || op == OLHU || op == OSH) && (a % 2 != 0));
    case (op)
      OLW:  val = w;
      OLH:  val = (h >= 16'h8000) ? {16'hFFFF, h} : {16'h0000, h};
      OLHU: val = {16'h0000, h};
      OLB:  val = (b >= 8'h80) ? {24'hFFFFFF, b} : {24'h000000, b};
      OLBU: val = {24'h000000, b};
      default: val = 32'd0;
    endcase
    case (op)
      OSH:     nw = (w & ~(32'hFFFF << shh)) | ((wd & 32'hFFFF) << shh);
      OSB:     nw = (w & ~(32'hFF << sb)) | ((wd & 32'hFF) << sb);
      default: nw = wd;
    endcase
    if (bad) begin
      exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0));
    end else if (op <= OLBU) begin
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, base, 32'd0));
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, val, 32'd0, 32'd0));
    end else if (op == OSW) begin
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, base, wd));
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0));
    end else begin
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, base, 32'd0));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, base, nw));
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0));
    end
  endfunction

  // Compare process: every cycle, DUT outputs against the model timeline.
  initial begin
    exp_t e;
    logic idle;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("mem_we_in_reset", 32'(bus.mem_we), 32'd0);
        exp_q.delete();
      end else begin
        idle = (exp_q.size() == 0);
        if (idle) e = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        else      e = exp_q.pop_front();
        chk("req_ready", 32'(bus.req_ready), 32'(e.ready));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(e.rv));
        chk("rsp_err",   32'(bus.rsp_err),   32'(e.err));
        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        chk("mem_we",    32'(bus.mem_we),    32'(e.we));
        chk("mem_addr",  bus.mem_addr,  e.addr);
        chk("mem_wdata", bus.mem_wdata, e.wdata);
        if (e.we) model_mem[e.addr[11:2]] = e.wdata;
        if (idle && bus.req_valid) model_accept(bus.req_op, bus.req_addr, bus.req_wdata);
      end
    end
  end

  // Issue one request, wait for its response; lat=0 means no response.
  task automatic do_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    logic hs;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = a;
    bus.req_wdata = wd; bus.req_pc = bus.req_pc + 32'd4;
    hs = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin hs = 1'b1; break; end
    end
    if (!hs) chk("handshake_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0; rd = 32'd0; er = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin lat = i; rd = bus.rsp_rdata; er = bus.rsp_err; break; end
    end
  endtask

  task automatic run_chk(string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd,
                         input logic exp_er, input int exp_lat);
    logic [31:0] rd;
    logic er;
    int lat;
    do_req(op, a, wd, rd, er, lat);
    chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({name, "_err"}, 32'(er), 32'(exp_er));
    chk({name, "_rdata"}, rd, exp_rd);
  endtask

  initial begin
    int first, second;
    logic [31:0] rd;
    logic er;
    int lat;
    bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_addr = 32'd0;
    bus.req_wdata = 32'd0; bus.req_pc = 32'h0000_0100;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("reset_ready", 32'(bus.req_ready), 32'd1);
    chk("reset_mem_we", 32'(bus.mem_we), 32'd0);

    run_chk("sw_deadbeef", OSW, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 2);
    chk("mem_after_sw", tbmem[4], 32'hDEADBEEF);
    run_chk("sw_init", OSW, 32'h10, 32'h80FF7F01, 32'd0, 1'b0, 2);
    run_chk("lb_13",  OLB,  32'h13, 32'd0, 32'hFFFFFF80, 1'b0, 2);
    run_chk("lbu_13", OLBU, 32'h13, 32'd0, 32'h00000080, 1'b0, 2);
    run_chk("lh_10",  OLH,  32'h10, 32'd0, 32'h00007F01, 1'b0, 2);
    run_chk("lh_12",  OLH,  32'h12, 32'd0, 32'hFFFF80FF, 1'b0, 2);
    run_chk("lhu_12", OLHU, 32'h12, 32'd0, 32'h000080FF, 1'b0, 2);
    run_chk("lw_10",  OLW,  32'h10, 32'd0, 32'h80FF7F01, 1'b0, 2);
    run_chk("sb_11",  OSB,  32'h11, 32'h000000AA, 32'd0, 1'b0, 3);
    chk("mem_after_sb", tbmem[4], 32'h80FFAA01);

    run_chk("lw_mis",  OLW, 32'h12,   32'd0, 32'd0, 1'b1, 1);
    run_chk("sh_mis",  OSH, 32'h11,   32'h5555, 32'd0, 1'b1, 1);
    run_chk("sw_oow",  OSW, 32'h1000, 32'h12345678, 32'd0, 1'b1, 1);
    chk("mem_after_errs", tbmem[4], 32'h80FFAA01);

    run_chk("sw_top", OSW, 32'hFFC, 32'h01020304, 32'd0, 1'b0, 2);
    run_chk("sb_top", OSB, 32'hFFF, 32'h0000005A, 32'd0, 1'b0, 3);
    chk("mem_top", tbmem[1023], 32'h5A020304);

    // SH whose MERGE cycle is hit by reset: no write, no response.
    run_chk("sw_20", OSW, 32'h20, 32'h11111111, 32'd0, 1'b0, 2);
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_op = OSH; bus.req_addr = 32'h20; bus.req_wdata = 32'h1234;
    first = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin first = i; break; end
    end
    chk("sh_rst_handshake", 32'(first >= 0), 32'd1);
    @(posedge clk); #1 bus.req_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("sh_rst_ready", 32'(bus.req_ready), 32'd1);
    chk("sh_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("sh_rst_mem", tbmem[8], 32'h11111111);
    run_chk("lw_20", OLW, 32'h20, 32'd0, 32'h11111111, 1'b0, 2);

    // Back-to-back with req_valid held: second handshake three cycles later.
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_op = OLW; bus.req_addr = 32'h10;
    first = -1; second = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        if (first < 0) begin
          first = i;
          @(posedge clk); #1;
          bus.req_op = OLBU; bus.req_addr = 32'h13;
        end else begin
          second = i;
          break;
        end
      end
    end
    @(posedge clk); #1 bus.req_valid = 1'b0;
    lat = 0; rd = 32'd0; er = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin lat = i; rd = bus.rsp_rdata; er = bus.rsp_err; break; end
    end
    chk("b2b_gap", 32'(second - first), 32'd3);
    chk("b2b_lat", 32'(lat), 32'd2);
    chk("b2b_rdata", rd, 32'h00000080);
    chk("b2b_err", 32'(er), 32'd0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
